mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//   Sequencer that feeds the 16-to-1 mux_f stage: drives its 4-bit select S16
//   through channels 0..15, waits a settle time per channel, and samples the
//   mux output f into a 16-bit snapshot word. Delivers the word to a consumer
//   with a Valid/Ack handshake. Sits between the mux tree and downstream logic.
// PARAMETERS
//   SETTLE  1   extra cycles held on each channel before f is sampled (0..15)
// PORTS
//   Clock    in   1   single system clock, rising edge
//   Resetn   in   1   asynchronous, active-low reset
//   Start    in   1   request a 16-channel scan; accepted only in IDLE or with Ack in DONE
//   f        in   1   mux_f output for the currently selected channel
//   Ack      in   1   consumer has taken Sample; clears Valid
//   S16      out  4   channel select to mux_f (registered)
//   Sample   out  16  snapshot; bit k = value of f while S16 == k
//   Busy     out  1   high while a scan is in progress (WAIT state)
//   Valid    out  1   Sample complete and stable; held until Ack
// BEHAVIOUR
//   Reset (Resetn=0, async): state=IDLE, S16=0, Sample=0, Busy=0, Valid=0, cnt=0.
//   States: IDLE, WAIT, DONE (2-bit encoding).
//   IDLE: Start=1 -> S16<=0, cnt<=SETTLE, go WAIT. Otherwise hold all outputs.
//   WAIT: Busy=1. cnt!=0 -> cnt<=cnt-1. cnt==0 -> Sample[S16]<=f;
//     if S16==15 go DONE, Valid<=1; else S16<=S16+1, cnt<=SETTLE.
//   DONE: Valid=1, Sample frozen, S16 held at 15.
//     Ack=1, Start=0 -> Valid<=0, go IDLE.
//     Ack=1, Start=1 -> Valid<=0, S16<=0, cnt<=SETTLE, go WAIT (back-to-back).
//     Ack=0 -> stay; Start ignored.
//   Timing: each channel occupies SETTLE+1 clock edges. Valid rises exactly
//     16*(SETTLE+1) edges after the edge that accepts Start (32 for SETTLE=1).
//   f is sampled on the last edge of a channel's slot, i.e. after S16 has been
//     stable for SETTLE+1 cycles; f is treated as combinational from S16.
//   Start during WAIT is ignored (not queued). Ack outside DONE is ignored.
//   S16 increments without wrap; the 15->0 transition happens only on a new Start.
//   Sample bits for channels not yet visited retain their previous-scan values;
//     consumers read Sample only while Valid=1.
//   Resetn asserted mid-scan: immediate return to reset values, scan discarded.
//   Busy and Valid are never high together; Busy=(state==WAIT), Valid=(state==DONE).
// STRUCTURE
//   Shared header: state encodings (IDLE/WAIT/DONE), NCH=16, select width 4.
//   One natural sub-module: settle_timer (loadable down-counter, 4-bit, with
//     zero flag); the FSM, channel counter and Sample register stay in the top.
//   mux_f is not instantiated inside; the bench connects S16/f to a mux_f instance.
// TESTING
//   Bench: mux_scan_ctrl + mux_f, W driven by bench, SETTLE=1 unless stated.
//   1 W=16'hA5C3, pulse Start -> Valid after 32 cycles, Sample maps W[k] to bit k,
//     S16 steps 0..15, each value held 2 cycles.
//   2 SETTLE=0, W=all 1s -> Valid after 16 cycles, Sample=16'hFFFF, S16 changes every cycle.
//   3 Hold Ack=0 for 10 cycles in DONE with Start pulses -> Valid stays 1, Sample
//     unchanged, no new scan; Ack=1 -> Valid=0 next edge, IDLE.
//   4 Ack=1 and Start=1 together in DONE -> Valid=0, S16=0, Busy=1 next edge;
//     second Sample correct after a further 32 cycles.
//   5 Resetn low at channel 7 mid-scan -> all outputs 0 immediately (async);
//     after release, a Start gives a complete correct scan.
//   6 Start pulses during WAIT and Ack during IDLE/WAIT -> no effect on timing or Sample.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: channel count, widths, states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_ctrl_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable 4-bit down-counter with zero flag; times the per-channel settle slot.
// Latency: load/decrement visible one edge later; zero flag is combinational.
// Backpressure: none; decrement saturates at zero.
module mux_scan_ctrl_settle_timer
    import mux_scan_ctrl_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; never count below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all 16 channels, samples f per channel into a snapshot word.
// Latency: each channel takes SETTLE+1 edges; Valid rises 16*(SETTLE+1) edges after Start.
// Backpressure: Valid/Sample held in DONE until Ack; Start ignored while busy or unacknowledged.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             f,
    input  logic             Ack,
    output logic [SEL_W-1:0] S16,
    output logic [NCH-1:0]   Sample,
    output logic             Busy,
    output logic             Valid
);

    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] s16_q, s16_d;
    logic [NCH-1:0]   sample_q, sample_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;

    mux_scan_ctrl_settle_timer u_timer (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (tmr_load),
        .load_val (SETTLE_V),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Scan sequencing: launch, per-channel settle/sample, hold result until acknowledged.
    always_comb begin
        state_d  = state_q;
        s16_d    = s16_q;
        sample_d = sample_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d  = ST_WAIT;
                    s16_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    // Last edge of this channel's slot: select has been stable SETTLE+1 cycles.
                    sample_d[s16_q] = f;
                    if (s16_q == LAST_CH) begin
                        state_d = ST_DONE;
                    end else begin
                        s16_d    = s16_q + 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    if (Start) begin
                        // Back-to-back scan: the acknowledging edge also launches the next scan.
                        state_d  = ST_WAIT;
                        s16_d    = '0;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, select and snapshot registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            s16_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            s16_q    <= s16_d;
            sample_q <= sample_d;
        end
    end

    assign S16    = s16_q;
    assign Sample = sample_q;
    assign Busy   = (state_q == ST_WAIT);
    assign Valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE=1 (index 0), one with SETTLE=0 (index 1).
// Each instance's f is a behavioural 16:1 mux of a bench-driven word W.
// Expected values come from the scan timing rules computed with arithmetic.
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rstn;
    logic        start [2];
    logic        ack   [2];
    logic [15:0] w     [2];
    logic        f     [2];
    logic [3:0]  s16   [2];
    logic [15:0] sample[2];
    logic        busy  [2];
    logic        valid [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mux_f: f is W bit selected by S16.
    assign f[0] = w[0][s16[0]];
    assign f[1] = w[1][s16[1]];

    mux_scan_ctrl #(.SETTLE(1)) dut_a (
        .Clock  (clk),
        .Resetn (rstn),
        .Start  (start[0]),
        .f      (f[0]),
        .Ack    (ack[0]),
        .S16    (s16[0]),
        .Sample (sample[0]),
        .Busy   (busy[0]),
        .Valid  (valid[0])
    );

    mux_scan_ctrl #(.SETTLE(0)) dut_b (
        .Clock  (clk),
        .Resetn (rstn),
        .Start  (start[1]),
        .f      (f[1]),
        .Ack    (ack[1]),
        .S16    (s16[1]),
        .Sample (sample[1]),
        .Busy   (busy[1]),
        .Valid  (valid[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic check_idle_outs(input int d, input string tag);
        check({tag, "_busy"},  32'(busy[d]),  32'd0);
        check({tag, "_valid"}, 32'(valid[d]), 32'd0);
    endtask

    // Launch a scan from IDLE; the launching edge puts the select on channel 0.
    task automatic begin_scan(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        check("launch_s16",   32'(s16[d]),   32'd0);
        check("launch_busy",  32'(busy[d]),  32'd1);
        check("launch_valid", 32'(valid[d]), 32'd0);
    endtask

    // Follow a scan edge by edge. Model: after edge n, S16 = n/(SETTLE+1) (capped at 15),
    // Busy until edge 16*(SETTLE+1), and bit k takes W as seen at edge (k+1)*(SETTLE+1).
    task automatic scan(input int d, input bit vary, input bit noise, input int stop_n,
                        output logic [15:0] exp);
        int per;
        int nlast;
        logic [15:0] wv;
        per   = settle_of(d) + 1;
        nlast = 16 * per;
        exp   = '0;
        for (int n = 1; n <= nlast; n++) begin
            if (stop_n != 0 && n > stop_n) break;
            if (vary) w[d] = 16'($urandom);
            wv = w[d];
            if (noise) begin
                start[d] = 1'($urandom_range(0, 1));
                ack[d]   = 1'($urandom_range(0, 1));
            end
            tick();
            if (n % per == 0) exp[n / per - 1] = wv[n / per - 1];
            check("scan_s16",   32'(s16[d]),   (n < nlast) ? 32'(n / per) : 32'd15);
            check("scan_busy",  32'(busy[d]),  (n < nlast) ? 32'd1 : 32'd0);
            check("scan_valid", 32'(valid[d]), (n == nlast) ? 32'd1 : 32'd0);
        end
        start[d] = 1'b0;
        ack[d]   = 1'b0;
        if (stop_n == 0) check("scan_sample", 32'(sample[d]), 32'(exp));
    endtask

    initial begin
        logic [15:0] exp;
        logic [15:0] held;

        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            ack[i]   = 1'b0;
            w[i]     = '0;
        end
        #12;
        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            check("rst_s16",    32'(s16[i]),    32'd0);
            check("rst_sample", 32'(sample[i]), 32'd0);
            check_idle_outs(i, "rst");
        end
        rstn = 1'b1;
        tick();

        // 1: fixed pattern, SETTLE=1.
        w[0] = 16'hA5C3;
        begin_scan(0);
        scan(0, 1'b0, 1'b0, 0, exp);
        check("t1_pattern", 32'(sample[0]), 32'h0000A5C3);

        // 2: SETTLE=0, all ones.
        w[1] = 16'hFFFF;
        begin_scan(1);
        scan(1, 1'b0, 1'b0, 0, exp);
        check("t2_pattern", 32'(sample[1]), 32'h0000FFFF);

        // 3: no Ack in DONE with Start pulses: result held, no new scan.
        held = 16'hA5C3;
        w[0] = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            start[0] = 1'($urandom_range(0, 1));
            tick();
            check("t3_valid",  32'(valid[0]),  32'd1);
            check("t3_busy",   32'(busy[0]),   32'd0);
            check("t3_s16",    32'(s16[0]),    32'd15);
            check("t3_sample", 32'(sample[0]), 32'(held));
        end
        start[0] = 1'b0;
        ack[0]   = 1'b1;
        tick();
        ack[0]   = 1'b0;
        check_idle_outs(0, "t3_ack");
        check("t3_ack_s16",    32'(s16[0]),    32'd15);
        check("t3_ack_sample", 32'(sample[0]), 32'(held));
        // Ack while IDLE does nothing.
        ack[0] = 1'b1;
        tick();
        tick();
        ack[0] = 1'b0;
        check_idle_outs(0, "t3_idle");
        check("t3_idle_sample", 32'(sample[0]), 32'(held));

        // 4: back-to-back Ack+Start in DONE.
        begin_scan(0);
        scan(0, 1'b1, 1'b0, 0, exp);
        ack[0]   = 1'b1;
        start[0] = 1'b1;
        tick();
        ack[0]   = 1'b0;
        start[0] = 1'b0;
        check("t4_valid", 32'(valid[0]), 32'd0);
        check("t4_s16",   32'(s16[0]),   32'd0);
        check("t4_busy",  32'(busy[0]),  32'd1);
        scan(0, 1'b1, 1'b0, 0, exp);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        check_idle_outs(0, "t4_end");
        // Instance b still waits in DONE from test 2.
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        check_idle_outs(1, "t4_b_end");

        // 5: asynchronous reset mid-scan at channel 7.
        begin_scan(0);
        scan(0, 1'b1, 1'b0, 14, exp);
        check("t5_at_ch7", 32'(s16[0]), 32'd7);
        #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("t5_rst_s16",    32'(s16[i]),    32'd0);
            check("t5_rst_sample", 32'(sample[i]), 32'd0);
            check_idle_outs(i, "t5_rst");
        end
        tick();
        rstn = 1'b1;
        tick();
        check_idle_outs(0, "t5_rel");
        begin_scan(0);
        scan(0, 1'b1, 1'b0, 0, exp);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;

        // 6: Start/Ack noise during WAIT has no effect, on both instances.
        for (int i = 0; i < 2; i++) begin
            begin_scan(i);
            scan(i, 1'b1, 1'b1, 0, exp);
            ack[i] = 1'b1;
            tick();
            ack[i] = 1'b0;
            check_idle_outs(i, "t6_end");
            check("t6_sample_held", 32'(sample[i]), 32'(exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
